motor_ctrl_param: RTL and testbench

Parametrised successor to the single-motor up/down controller FSM. Drives one motor up or down from an activate request and two end-of-travel limit switches. Adds a per-move watchdog timeout, a post-move dead time before the next move is accepted, an abort input, a latched fault state with explicit clear, and a saturating completed-move counter. Sits between the button/limit-switch synchroniser and the motor driver.

---
 rtl/motor_ctrl_param.sv | 150 +++++++++++++++
 tb/tb_motor_ctrl_param.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ctrl_param.sv
// Single-motor up/down controller with per-move watchdog, post-move dead time,
// abort, latched fault with explicit clear, and a saturating completed-move counter.
//
// state  | meaning
// IDLE   | motor off, waiting for activate
// MV_UP  | driving up until up_max, stop_req or watchdog expiry
// MV_DN  | driving down until dn_max, stop_req or watchdog expiry
// COOL   | dead time after a move, requests ignored
// FAULT  | drives off, latched until clr_fault with consistent limits
module motor_ctrl_param #(
    parameter int TIMEOUT  = 16,
    parameter int DEAD_CYC = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             activate,
    input  logic             up_max,
    input  logic             dn_max,
    input  logic             stop_req,
    input  logic             clr_fault,
    output logic             up_M,
    output logic             dn_M,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] move_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MV_UP = 3'd1,
        MV_DN = 3'd2,
        COOL  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam int TMR_MAX = (TIMEOUT > DEAD_CYC) ? TIMEOUT : DEAD_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] MOVE_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] COOL_LOAD = TMR_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
    // With no dead time a finished move returns straight to IDLE.
    localparam state_t MOVE_END = (DEAD_CYC > 0) ? COOL : IDLE;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] tmr;
    logic             cnt_inc;
    logic             both_lim;

    assign both_lim = up_max & dn_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (both_lim) begin
                    state_nxt = FAULT;
                end else if (activate) begin
                    state_nxt = dn_max ? MV_UP : MV_DN;
                end
            end
            MV_UP: begin
                if (up_max) begin
                    state_nxt = MOVE_END;
                    cnt_inc   = 1'b1;
                end else if (stop_req) begin
                    state_nxt = MOVE_END;
                end else if (tmr == '0) begin
                    state_nxt = FAULT;
                end
            end
            MV_DN: begin
                if (dn_max) begin
                    state_nxt = MOVE_END;
                    cnt_inc   = 1'b1;
                end else if (stop_req) begin
                    state_nxt = MOVE_END;
                end else if (tmr == '0) begin
                    state_nxt = FAULT;
                end
            end
            COOL: begin
                if (both_lim) begin
                    state_nxt = FAULT;
                end else if (tmr == '0) begin
                    state_nxt = IDLE;
                end
            end
            FAULT: begin
                if (clr_fault && !both_lim) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Down-counter reloaded on every state entry; zero is the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= '0;
        end else if (state_nxt != state) begin
            case (state_nxt)
                MV_UP, MV_DN: tmr <= MOVE_LOAD;
                COOL:         tmr <= COOL_LOAD;
                default:      tmr <= '0;
            endcase
        end else if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            move_cnt <= '0;
        end else if (cnt_inc && (move_cnt != '1)) begin
            move_cnt <= move_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        up_M  = 1'b0;
        dn_M  = 1'b0;
        busy  = 1'b0;
        fault = 1'b0;
        case (state)
            MV_UP: begin
                up_M = 1'b1;
                busy = 1'b1;
            end
            MV_DN: begin
                dn_M = 1'b1;
                busy = 1'b1;
            end
            COOL:    busy  = 1'b1;
            FAULT:   fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_motor_ctrl_param.sv
// Bench for motor_ctrl_param: directed scenarios on a default-parameter instance,
// plus a short-timeout / no-dead-time / 2-bit-counter instance, and a random run against a model.
module tb_motor_ctrl_param;

    logic       clk = 1'b0;
    logic       rst, activate, up_max, dn_max, stop_req, clr_fault;
    logic       a_up, a_dn, a_busy, a_fault;
    logic [7:0] a_cnt;
    logic       b_up, b_dn, b_busy, b_fault;
    logic [1:0] b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    motor_ctrl_param dut_a (
        .clk(clk), .rst(rst), .activate(activate), .up_max(up_max), .dn_max(dn_max),
        .stop_req(stop_req), .clr_fault(clr_fault),
        .up_M(a_up), .dn_M(a_dn), .busy(a_busy), .fault(a_fault), .move_cnt(a_cnt)
    );

    motor_ctrl_param #(.TIMEOUT(4), .DEAD_CYC(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .activate(activate), .up_max(up_max), .dn_max(dn_max),
        .stop_req(stop_req), .clr_fault(clr_fault),
        .up_M(b_up), .dn_M(b_dn), .busy(b_busy), .fault(b_fault), .move_cnt(b_cnt)
    );

    // Reference model: direction of travel, cycles moved, dead time left, fault flag, moves.
    int m_dir[2];
    int m_moved[2];
    int m_cool[2];
    int m_cnt[2];
    bit m_flt[2];

    function automatic int p_to(input int k);
        return (k == 0) ? 16 : 4;
    endfunction
    function automatic int p_dc(input int k);
        return (k == 0) ? 2 : 0;
    endfunction
    function automatic int p_cmax(input int k);
        return (k == 0) ? 255 : 3;
    endfunction

    function automatic void model_step(input int k);
        bit both;
        bit lim;
        both = up_max && dn_max;
        if (rst) begin
            m_dir[k] = 0; m_moved[k] = 0; m_cool[k] = 0; m_cnt[k] = 0; m_flt[k] = 0;
        end else if (m_flt[k]) begin
            if (clr_fault && !both) m_flt[k] = 0;
        end else if (m_dir[k] != 0) begin
            lim = (m_dir[k] > 0) ? up_max : dn_max;
            if (lim || stop_req) begin
                if (lim && m_cnt[k] < p_cmax(k)) m_cnt[k]++;
                m_dir[k]  = 0;
                m_cool[k] = p_dc(k);
            end else begin
                m_moved[k]++;
                if (m_moved[k] == p_to(k)) begin
                    m_dir[k] = 0;
                    m_flt[k] = 1;
                end
            end
        end else if (m_cool[k] > 0) begin
            if (both) begin
                m_cool[k] = 0;
                m_flt[k]  = 1;
            end else begin
                m_cool[k]--;
            end
        end else begin
            if (both) begin
                m_flt[k] = 1;
            end else if (activate) begin
                m_dir[k]   = dn_max ? 1 : -1;
                m_moved[k] = 0;
            end
        end
    endfunction

    function automatic logic [11:0] m_out(input int k);
        logic [7:0] c;
        c = 8'(m_cnt[k]);
        return {m_dir[k] > 0, m_dir[k] < 0, (m_dir[k] != 0) || (m_cool[k] > 0), m_flt[k], c};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({a_up, a_dn, a_busy, a_fault, a_cnt} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_a: got %03h want 000", {a_up, a_dn, a_busy, a_fault, a_cnt});
        end
        n_checks++;
        if ({b_up, b_dn, b_busy, b_fault, b_cnt} !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_b: got %02h want 00", {b_up, b_dn, b_busy, b_fault, b_cnt});
        end
    endtask

    task automatic test_down_move();
        activate = 1'b1; up_max = 1'b1; dn_max = 1'b0;
        tick();
        activate = 1'b0; up_max = 1'b0;
        n_checks++;
        if ({a_up, a_dn, a_busy, a_fault} !== 4'b0110) begin
            n_fail++;
            $display("FAIL down_start: got %b want 0110", {a_up, a_dn, a_busy, a_fault});
        end
        tick();
        tick();
        dn_max = 1'b1;
        tick();
        dn_max = 1'b0;
        n_checks++;
        if ({a_up, a_dn, a_busy, a_fault, a_cnt} !== {4'b0010, 8'd1}) begin
            n_fail++;
            $display("FAIL down_limit_cool1: got %03h want 201", {a_up, a_dn, a_busy, a_fault, a_cnt});
        end
        tick();
        n_checks++;
        if (a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL down_cool2: busy got %b want 1", a_busy);
        end
        tick();
        n_checks++;
        if ({a_up, a_dn, a_busy, a_fault, a_cnt} !== {4'b0000, 8'd1}) begin
            n_fail++;
            $display("FAIL down_idle: got %03h want 001", {a_up, a_dn, a_busy, a_fault, a_cnt});
        end
    endtask

    task automatic test_timeout();
        int n_up;
        activate = 1'b1; dn_max = 1'b1; up_max = 1'b0;
        tick();
        activate = 1'b0; dn_max = 1'b0;
        n_up = (a_up === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40 && a_up === 1'b1; i++) begin
            tick();
            if (a_up === 1'b1) n_up++;
        end
        n_checks++;
        if (n_up != 16) begin
            n_fail++;
            $display("FAIL timeout_len: up_M high %0d cycles want 16", n_up);
        end
        n_checks++;
        if ({a_up, a_dn, a_busy, a_fault, a_cnt} !== {4'b0001, 8'd1}) begin
            n_fail++;
            $display("FAIL timeout_fault: got %03h want 101", {a_up, a_dn, a_busy, a_fault, a_cnt});
        end
    endtask

    task automatic test_fault_clear();
        clr_fault = 1'b1; up_max = 1'b1; dn_max = 1'b1;
        tick();
        n_checks++;
        if (a_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_blocked: fault got %b want 1", a_fault);
        end
        up_max = 1'b0; dn_max = 1'b0;
        tick();
        clr_fault = 1'b0;
        n_checks++;
        if ({a_up, a_dn, a_busy, a_fault} !== 4'b0000) begin
            n_fail++;
            $display("FAIL clr_ok: got %b want 0000", {a_up, a_dn, a_busy, a_fault});
        end
    endtask

    task automatic test_abort();
        activate = 1'b1;
        tick();
        activate = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (a_dn !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_moving: dn_M got %b want 1", a_dn);
        end
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        activate = 1'b1;
        n_checks++;
        if ({a_up, a_dn, a_busy, a_fault, a_cnt} !== {4'b0010, 8'd1}) begin
            n_fail++;
            $display("FAIL abort_cool: got %03h want 201", {a_up, a_dn, a_busy, a_fault, a_cnt});
        end
        tick();
        tick();
        n_checks++;
        if ({a_up, a_dn, a_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_ignore_act: got %b want 000", {a_up, a_dn, a_busy});
        end
        tick();
        activate = 1'b0;
        n_checks++;
        if (a_dn !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_accept_act: dn_M got %b want 1", a_dn);
        end
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_contradiction();
        up_max = 1'b1; dn_max = 1'b1;
        tick();
        n_checks++;
        if ({a_busy, a_fault} !== 2'b01) begin
            n_fail++;
            $display("FAIL idle_both_limits: got %b want 01", {a_busy, a_fault});
        end
        up_max = 1'b0; dn_max = 1'b0; clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        activate = 1'b1; up_max = 1'b1;
        tick();
        activate = 1'b0; up_max = 1'b0; dn_max = 1'b1;
        tick();
        up_max = 1'b1;
        tick();
        up_max = 1'b0; dn_max = 1'b0;
        n_checks++;
        if ({a_busy, a_fault, a_cnt} !== {2'b01, 8'd2}) begin
            n_fail++;
            $display("FAIL cool_both_limits: got %03h want 102", {a_busy, a_fault, a_cnt});
        end
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
    endtask

    task automatic test_reset_mid_move();
        activate = 1'b1; dn_max = 1'b1;
        tick();
        activate = 1'b0; dn_max = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({a_up, a_busy, a_cnt} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_mid_move: got %03h want 000", {a_up, a_busy, a_cnt});
        end
    endtask

    task automatic test_saturation();
        int want;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            want = (i + 1 > 3) ? 3 : i + 1;
            activate = 1'b1; dn_max = 1'b1;
            tick();
            activate = 1'b0; dn_max = 1'b0;
            tick();
            up_max = 1'b1;
            tick();
            up_max = 1'b0;
            n_checks++;
            if ({b_up, b_busy, b_cnt} !== {2'b00, 2'(want)}) begin
                n_fail++;
                $display("FAIL sat_move%0d: got %b want %b", i, {b_up, b_busy, b_cnt}, {2'b00, 2'(want)});
            end
            n_checks++;
            if (a_cnt !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL nosat_move%0d: got %0d want %0d", i, a_cnt, i + 1);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_a;
        logic [11:0] exp_b;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            activate  = ($urandom_range(0, 2) == 0);
            up_max    = ($urandom_range(0, 5) == 0);
            dn_max    = ($urandom_range(0, 5) == 0);
            stop_req  = ($urandom_range(0, 11) == 0);
            clr_fault = ($urandom_range(0, 3) == 0);
            tick();
            exp_a = m_out(0);
            exp_b = m_out(1);
            n_checks++;
            if ({a_up, a_dn, a_busy, a_fault, a_cnt} !== exp_a) begin
                n_fail++;
                $display("FAIL rand_a cyc %0d: got %03h want %03h", i, {a_up, a_dn, a_busy, a_fault, a_cnt}, exp_a);
            end
            n_checks++;
            if ({b_up, b_dn, b_busy, b_fault, 6'd0, b_cnt} !== exp_b) begin
                n_fail++;
                $display("FAIL rand_b cyc %0d: got %03h want %03h", i, {b_up, b_dn, b_busy, b_fault, 6'd0, b_cnt}, exp_b);
            end
        end
        rst = 1'b0; activate = 1'b0; up_max = 1'b0; dn_max = 1'b0;
        stop_req = 1'b0; clr_fault = 1'b0;
    endtask

    initial begin
        rst = 1'b1; activate = 1'b0; up_max = 1'b0; dn_max = 1'b0;
        stop_req = 1'b0; clr_fault = 1'b0;
        #2;
        test_reset();
        test_down_move();
        test_timeout();
        test_fault_clear();
        test_abort();
        test_contradiction();
        test_reset_mid_move();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
